// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
package regfile_pkg;
  typedef enum logic {RF_IDLE = 1'b0, RF_CLEAR = 1'b1} rf_state_t;

  localparam int DEF_XLEN     = 32;
  localparam int DEF_NREGS    = 32;
  localparam int DEF_NREAD    = 2;
  localparam int DEF_NWRITE   = 2;
  localparam int DEF_ZERO_REG = 1;
endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by decode, cleared by writeback.
// A set and a write to the same register in one cycle leaves the bit set.
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int NREGS    = DEF_NREGS,
  parameter int NREAD    = DEF_NREAD,
  parameter int NWRITE   = DEF_NWRITE,
  parameter int ZERO_REG = DEF_ZERO_REG,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clr_all,
  input  logic [NWRITE-1:0]     i_wr_eff,
  input  logic [NWRITE*AW-1:0]  i_wr_addr,
  input  logic                  i_set_en,
  input  logic [AW-1:0]         i_set_addr,
  input  logic [NREAD*AW-1:0]   i_rd_addr,
  output logic [NREAD-1:0]      o_rd_pending
);
  logic [NREGS-1:0] r_pend;
  logic [NREAD-1:0] w_rd_hit;
  logic             w_set_eff;

  assign w_set_eff = i_set_en && !((ZERO_REG != 0) && (i_set_addr == '0));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pend <= '0;
    end else if (i_clr_all) begin
      r_pend <= '0;
    end else begin
      for (int j = 0; j < NWRITE; j++) begin
        if (i_wr_eff[j]) r_pend[i_wr_addr[j*AW +: AW]] <= 1'b0;
      end
      if (w_set_eff) r_pend[i_set_addr] <= 1'b1;
    end
  end

  // A write landing this cycle resolves the hazard before the bit clears.
  always_comb begin
    w_rd_hit = '0;
    for (int i = 0; i < NREAD; i++) begin
      for (int j = 0; j < NWRITE; j++) begin
        if (i_wr_eff[j] && (i_wr_addr[j*AW +: AW] == i_rd_addr[i*AW +: AW])) w_rd_hit[i] = 1'b1;
      end
    end
  end

  always_comb begin
    o_rd_pending = '0;
    for (int i = 0; i < NREAD; i++) begin
      o_rd_pending[i] = r_pend[i_rd_addr[i*AW +: AW]] && !w_rd_hit[i];
    end
  end
endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with write-first bypass, write priority,
// conflict flag, pending scoreboard and a sequential clear sweep after reset/request.
module regfile_mp import regfile_pkg::*; #(
  parameter int XLEN     = DEF_XLEN,
  parameter int NREGS    = DEF_NREGS,
  parameter int NREAD    = DEF_NREAD,
  parameter int NWRITE   = DEF_NWRITE,
  parameter int ZERO_REG = DEF_ZERO_REG,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NREAD*AW-1:0]    i_rd_addr,
  output logic [NREAD*XLEN-1:0]  o_rd_data,
  output logic [NREAD-1:0]       o_rd_pending,
  input  logic [NWRITE-1:0]      i_wr_en,
  input  logic [NWRITE*AW-1:0]   i_wr_addr,
  input  logic [NWRITE*XLEN-1:0] i_wr_data,
  input  logic                   i_pend_set_en,
  input  logic [AW-1:0]          i_pend_set_addr,
  input  logic                   i_clr_req,
  output logic                   o_busy,
  output logic                   o_err_conflict
);
  rf_state_t         r_state;
  logic [AW-1:0]     r_clr_idx;
  logic [XLEN-1:0]   r_regs [NREGS];
  logic              r_err_conflict;
  logic              w_idle;
  logic              w_clr_all;
  logic              w_conflict;
  logic [NWRITE-1:0] w_wr_eff;

  assign w_idle         = (r_state == RF_IDLE);
  assign w_clr_all      = !w_idle || i_clr_req;
  assign o_busy         = !w_idle;
  assign o_err_conflict = r_err_conflict;

  always_comb begin
    w_wr_eff = '0;
    for (int j = 0; j < NWRITE; j++) begin
      w_wr_eff[j] = w_idle && i_wr_en[j] && !((ZERO_REG != 0) && (i_wr_addr[j*AW +: AW] == '0));
    end
  end

  always_comb begin
    w_conflict = 1'b0;
    for (int j = 0; j < NWRITE; j++) begin
      for (int k = j + 1; k < NWRITE; k++) begin
        if (w_wr_eff[j] && w_wr_eff[k] && (i_wr_addr[j*AW +: AW] == i_wr_addr[k*AW +: AW]))
          w_conflict = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= RF_CLEAR;
      r_clr_idx      <= '0;
      r_err_conflict <= 1'b0;
    end else begin
      r_err_conflict <= w_conflict;
      case (r_state)
        RF_CLEAR: begin
          if (r_clr_idx == AW'(NREGS - 1)) begin
            r_state   <= RF_IDLE;
            r_clr_idx <= '0;
          end else begin
            r_clr_idx <= r_clr_idx + 1'b1;
          end
        end
        default: begin
          if (i_clr_req) begin
            r_state   <= RF_CLEAR;
            r_clr_idx <= '0;
          end
        end
      endcase
    end
  end

  // Storage has no reset; the sweep zeroes it. Later ports overwrite earlier ones.
  always_ff @(posedge i_clk) begin
    if (r_state == RF_CLEAR) begin
      r_regs[r_clr_idx] <= '0;
    end else begin
      for (int j = 0; j < NWRITE; j++) begin
        if (w_wr_eff[j]) r_regs[i_wr_addr[j*AW +: AW]] <= i_wr_data[j*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    o_rd_data = '0;
    for (int i = 0; i < NREAD; i++) begin
      o_rd_data[i*XLEN +: XLEN] = r_regs[i_rd_addr[i*AW +: AW]];
      for (int j = 0; j < NWRITE; j++) begin
        if (w_wr_eff[j] && (i_wr_addr[j*AW +: AW] == i_rd_addr[i*AW +: AW]))
          o_rd_data[i*XLEN +: XLEN] = i_wr_data[j*XLEN +: XLEN];
      end
      if (((ZERO_REG != 0) && (i_rd_addr[i*AW +: AW] == '0)) || !w_idle)
        o_rd_data[i*XLEN +: XLEN] = '0;
    end
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .NREAD    (NREAD),
    .NWRITE   (NWRITE),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clr_all    (w_clr_all),
    .i_wr_eff     (w_wr_eff),
    .i_wr_addr    (i_wr_addr),
    .i_set_en     (i_pend_set_en),
    .i_set_addr   (i_pend_set_addr),
    .i_rd_addr    (i_rd_addr),
    .o_rd_pending (o_rd_pending)
  );
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic
// compared against an array-based reference model.
module tb_regfile_mp;
  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int NREAD  = 2;
  localparam int NWRITE = 2;
  localparam int AW     = 5;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [NREAD*AW-1:0]    rd_addr = '0;
  logic [NREAD*XLEN-1:0]  rd_data;
  logic [NREAD-1:0]       rd_pending;
  logic [NWRITE-1:0]      wr_en = '0;
  logic [NWRITE*AW-1:0]   wr_addr = '0;
  logic [NWRITE*XLEN-1:0] wr_data = '0;
  logic                   pend_set_en = 1'b0;
  logic [AW-1:0]          pend_set_addr = '0;
  logic                   clr_req = 1'b0;
  logic                   busy;
  logic                   err_conflict;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: register contents, pending bits, sweep cycles left, expected error flag.
  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_pend [NREGS];
  int              m_left;
  bit              m_err;

  regfile_mp dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_rd_addr       (rd_addr),
    .o_rd_data       (rd_data),
    .o_rd_pending    (rd_pending),
    .i_wr_en         (wr_en),
    .i_wr_addr       (wr_addr),
    .i_wr_data       (wr_data),
    .i_pend_set_en   (pend_set_en),
    .i_pend_set_addr (pend_set_addr),
    .i_clr_req       (clr_req),
    .o_busy          (busy),
    .o_err_conflict  (err_conflict)
  );

  always #5 clk = ~clk;

  function automatic logic [AW-1:0] rda(int i);
    return rd_addr[i*AW +: AW];
  endfunction

  function automatic logic [AW-1:0] wra(int j);
    return wr_addr[j*AW +: AW];
  endfunction

  function automatic bit wr_eff(int j);
    return (m_left == 0) && wr_en[j] && (wra(j) != 0);
  endfunction

  function automatic logic [XLEN-1:0] exp_rd(int i);
    logic [XLEN-1:0] v;
    if (m_left > 0 || rda(i) == 0) return '0;
    v = m_regs[rda(i)];
    for (int j = 0; j < NWRITE; j++)
      if (wr_eff(j) && wra(j) == rda(i)) v = wr_data[j*XLEN +: XLEN];
    return v;
  endfunction

  function automatic bit exp_pend(int i);
    if (m_left > 0 || rda(i) == 0) return 1'b0;
    for (int j = 0; j < NWRITE; j++)
      if (wr_eff(j) && wra(j) == rda(i)) return 1'b0;
    return m_pend[rda(i)];
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) begin
      m_regs[r] = '0;
      m_pend[r] = 1'b0;
    end
    m_left = NREGS;
    m_err  = 1'b0;
  endtask

  task automatic model_edge();
    bit c;
    if (rst) begin
      model_reset();
    end else if (m_left > 0) begin
      m_left--;
      m_err = 1'b0;
    end else begin
      c = 1'b0;
      for (int j = 0; j < NWRITE; j++)
        for (int k = j + 1; k < NWRITE; k++)
          if (wr_eff(j) && wr_eff(k) && wra(j) == wra(k)) c = 1'b1;
      for (int j = 0; j < NWRITE; j++)
        if (wr_eff(j)) begin
          m_regs[wra(j)] = wr_data[j*XLEN +: XLEN];
          m_pend[wra(j)] = 1'b0;
        end
      if (pend_set_en && pend_set_addr != 0) m_pend[pend_set_addr] = 1'b1;
      m_err = c;
      if (clr_req) model_reset();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    wr_en       = '0;
    pend_set_en = 1'b0;
    clr_req     = 1'b0;
  endtask

  task automatic rand_inputs(bit allow_clr);
    for (int i = 0; i < NREAD; i++)
      rd_addr[i*AW +: AW] = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, NREGS - 1));
    for (int j = 0; j < NWRITE; j++) begin
      wr_addr[j*AW +: AW]   = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, NREGS - 1));
      wr_data[j*XLEN +: XLEN] = $urandom;
    end
    wr_en         = NWRITE'($urandom);
    pend_set_en   = 1'($urandom);
    pend_set_addr = AW'($urandom_range(0, 7));
    clr_req       = allow_clr && ($urandom_range(0, 63) == 0);
  endtask

  task automatic test_reset();
    int cnt;
    idle_inputs();
    rd_addr = NREAD*AW'($urandom);
    rst = 1'b1;
    model_reset();
    #2;
    n_total++; if (busy !== 1'b1) $display("FAIL reset_busy got %b want 1", busy); else n_pass++;
    n_total++; if (err_conflict !== 1'b0) $display("FAIL reset_err got %b want 0", err_conflict); else n_pass++;
    n_total++; if (rd_pending !== '0) $display("FAIL reset_pending got %b want 0", rd_pending); else n_pass++;
    n_total++; if (rd_data !== '0) $display("FAIL reset_rd_data got %h want 0", rd_data); else n_pass++;
    tick();
    tick();
    rst = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      rd_addr = NREAD*AW'($urandom);
      wr_en   = '1;
      wr_data = {$urandom, $urandom};
      #2;
      n_total++; if (rd_data !== '0) $display("FAIL sweep_rd_zero got %h want 0", rd_data); else n_pass++;
      tick();
      cnt++;
    end
    n_total++; if (cnt != NREGS) $display("FAIL reset_sweep_len got %0d want %0d", cnt, NREGS); else n_pass++;
    idle_inputs();
    for (int r = 0; r < NREGS; r += 2) begin
      rd_addr = {AW'(r + 1), AW'(r)};
      #2;
      n_total++; if (rd_data !== '0) $display("FAIL post_reset_reg %0d got %h want 0", r, rd_data); else n_pass++;
      tick();
    end
  endtask

  task automatic test_write_bypass();
    idle_inputs();
    wr_en   = 2'b01;
    wr_addr = {AW'(0), AW'(5)};
    wr_data = {32'h0, 32'hDEADBEEF};
    rd_addr = {AW'(9), AW'(5)};
    #2;
    n_total++; if (rd_data[31:0] !== 32'hDEADBEEF) $display("FAIL bypass_same_cycle got %h want deadbeef", rd_data[31:0]); else n_pass++;
    n_total++; if (rd_data[63:32] !== exp_rd(1)) $display("FAIL bypass_other_port got %h want %h", rd_data[63:32], exp_rd(1)); else n_pass++;
    tick();
    wr_en = '0;
    #2;
    n_total++; if (rd_data[31:0] !== 32'hDEADBEEF) $display("FAIL write_stored got %h want deadbeef", rd_data[31:0]); else n_pass++;
    tick();
  endtask

  task automatic test_conflict();
    idle_inputs();
    wr_en   = 2'b11;
    wr_addr = {AW'(7), AW'(7)};
    wr_data = {32'h22, 32'h11};
    rd_addr = {AW'(7), AW'(7)};
    #2;
    n_total++; if (rd_data[31:0] !== 32'h22) $display("FAIL conflict_bypass got %h want 22", rd_data[31:0]); else n_pass++;
    n_total++; if (err_conflict !== 1'b0) $display("FAIL conflict_early got %b want 0", err_conflict); else n_pass++;
    tick();
    wr_en = '0;
    #2;
    n_total++; if (err_conflict !== 1'b1) $display("FAIL conflict_pulse got %b want 1", err_conflict); else n_pass++;
    n_total++; if (rd_data[63:32] !== 32'h22) $display("FAIL conflict_winner got %h want 22", rd_data[63:32]); else n_pass++;
    tick();
    #2;
    n_total++; if (err_conflict !== 1'b0) $display("FAIL conflict_one_cycle got %b want 0", err_conflict); else n_pass++;
  endtask

  task automatic test_zero_reg();
    idle_inputs();
    wr_en         = 2'b01;
    wr_addr       = {AW'(0), AW'(0)};
    wr_data       = {32'h0, 32'hFFFFFFFF};
    pend_set_en   = 1'b1;
    pend_set_addr = '0;
    rd_addr       = {AW'(0), AW'(0)};
    #2;
    n_total++; if (rd_data !== '0) $display("FAIL zero_bypass got %h want 0", rd_data); else n_pass++;
    tick();
    idle_inputs();
    #2;
    n_total++; if (rd_data !== '0) $display("FAIL zero_stored got %h want 0", rd_data); else n_pass++;
    n_total++; if (rd_pending !== '0) $display("FAIL zero_pending got %b want 0", rd_pending); else n_pass++;
    tick();
  endtask

  task automatic test_scoreboard();
    idle_inputs();
    rd_addr = {AW'(3), AW'(3)};
    wr_en   = 2'b01;
    wr_addr = {AW'(0), AW'(3)};
    wr_data = {32'h0, $urandom};
    tick();
    wr_en         = '0;
    pend_set_en   = 1'b1;
    pend_set_addr = AW'(3);
    #2;
    n_total++; if (rd_pending[0] !== 1'b0) $display("FAIL pend_not_yet got %b want 0", rd_pending[0]); else n_pass++;
    tick();
    pend_set_en = 1'b0;
    #2;
    n_total++; if (rd_pending[0] !== 1'b1) $display("FAIL pend_set got %b want 1", rd_pending[0]); else n_pass++;
    tick();
    wr_en   = 2'b10;
    wr_addr = {AW'(3), AW'(1)};
    wr_data = {$urandom, $urandom};
    #2;
    n_total++; if (rd_pending !== 2'b00) $display("FAIL pend_masked_by_write got %b want 00", rd_pending); else n_pass++;
    tick();
    wr_en = '0;
    #2;
    n_total++; if (rd_pending[0] !== 1'b0) $display("FAIL pend_cleared got %b want 0", rd_pending[0]); else n_pass++;
    tick();
    wr_en         = 2'b01;
    wr_addr       = {AW'(0), AW'(3)};
    pend_set_en   = 1'b1;
    pend_set_addr = AW'(3);
    tick();
    idle_inputs();
    #2;
    n_total++; if (rd_pending[0] !== 1'b1) $display("FAIL pend_set_wins got %b want 1", rd_pending[0]); else n_pass++;
    tick();
  endtask

  task automatic test_random(int n);
    for (int c = 0; c < n; c++) begin
      rand_inputs(1'b1);
      #2;
      n_total++; if (busy !== (m_left > 0)) $display("FAIL rnd_busy cyc %0d got %b want %b", c, busy, m_left > 0); else n_pass++;
      n_total++; if (err_conflict !== m_err) $display("FAIL rnd_err cyc %0d got %b want %b", c, err_conflict, m_err); else n_pass++;
      for (int i = 0; i < NREAD; i++) begin
        n_total++;
        if (rd_data[i*XLEN +: XLEN] !== exp_rd(i))
          $display("FAIL rnd_rd%0d cyc %0d addr %0d got %h want %h", i, c, rda(i), rd_data[i*XLEN +: XLEN], exp_rd(i));
        else n_pass++;
        n_total++;
        if (rd_pending[i] !== exp_pend(i))
          $display("FAIL rnd_pend%0d cyc %0d addr %0d got %b want %b", i, c, rda(i), rd_pending[i], exp_pend(i));
        else n_pass++;
      end
      tick();
    end
    idle_inputs();
    while (m_left > 0) tick();
  endtask

  task automatic test_clear();
    int cnt;
    idle_inputs();
    for (int r = 1; r < NREGS; r++) begin
      wr_en         = 2'b01;
      wr_addr       = {AW'(0), AW'(r)};
      wr_data       = {32'h0, 32'(r) * 32'h01010101};
      pend_set_en   = 1'b1;
      pend_set_addr = AW'(r);
      tick();
    end
    idle_inputs();
    rd_addr = {AW'(31), AW'(17)};
    #2;
    n_total++; if (rd_data[31:0] !== 32'h11111111) $display("FAIL fill_check got %h want 11111111", rd_data[31:0]); else n_pass++;
    n_total++; if (rd_pending !== 2'b11) $display("FAIL fill_pending got %b want 11", rd_pending); else n_pass++;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      rd_addr = NREAD*AW'($urandom);
      #2;
      n_total++; if (rd_pending !== '0) $display("FAIL clr_pending got %b want 0", rd_pending); else n_pass++;
      tick();
      cnt++;
    end
    n_total++; if (cnt != NREGS) $display("FAIL clr_sweep_len got %0d want %0d", cnt, NREGS); else n_pass++;
    for (int r = 0; r < NREGS; r += 2) begin
      rd_addr = {AW'(r + 1), AW'(r)};
      #2;
      n_total++; if (rd_data !== '0 || rd_pending !== '0)
        $display("FAIL post_clr_reg %0d got %h/%b want 0/0", r, rd_data, rd_pending); else n_pass++;
      tick();
    end
    // Reset lands at sweep index 10 and must restart the full count.
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    model_reset();
    #2;
    n_total++; if (busy !== 1'b1) $display("FAIL midrst_busy got %b want 1", busy); else n_pass++;
    tick();
    rst = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
    n_total++; if (cnt != NREGS) $display("FAIL midrst_sweep_len got %0d want %0d", cnt, NREGS); else n_pass++;
    // Held request re-triggers a sweep on every return to idle.
    clr_req = 1'b1;
    for (int c = 0; c < 70; c++) begin
      #2;
      n_total++; if (busy !== (m_left > 0)) $display("FAIL held_clr cyc %0d got %b want %b", c, busy, m_left > 0); else n_pass++;
      tick();
    end
    clr_req = 1'b0;
    while (m_left > 0) tick();
  endtask

  initial begin
    #1;
    test_reset();
    test_write_bypass();
    test_conflict();
    test_zero_reg();
    test_scoreboard();
    test_random(400);
    test_clear();
    test_random(200);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout after %0d checks", n_total);
    $fatal(1);
  end
endmodule
